// File: rtl/tone_player.sv
// -----------------------------------------------------------------------------
// tone_player
//
// Plays one note (or rest) per request as a square wave on a buzzer pin.
// A request is taken only in IDLE. It latches the note code, octave and
// duration. The note then plays for max(dur_units,1) beat units and the FSM
// returns to IDLE, optionally via a silent inter-note GAP.
//
// Optional feature macro:
//   NOTE_GAP_EN  - when defined, every note that runs to completion is
//                  followed by GAP_MS of silence with note_ready low.
//
// Parameters:
//   CLK_HZ   system clock frequency in Hz
//   BEAT_MS  length of one duration unit in ms
//   GAP_MS   inter-note silence in ms (used only with NOTE_GAP_EN)
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       asynchronous active-low reset
//   note_valid  note request strobe
//   note_code   1..7 = do..si, 0 and 8..15 = rest
//   octave      00 low, 01 middle, 10 high, 11 middle
//   dur_units   note length in beat units (0 behaves as 1)
//   stop        synchronous abort of the note in progress
//   note_ready  high when a request can be accepted (IDLE)
//   speaker     square-wave tone output
//   playing     high while a note or rest is being timed
//   cur_note    latched note code of the note in progress, 0 otherwise
//   led_out     one-hot of cur_note (bit note-1), 0 for rest/idle
// -----------------------------------------------------------------------------
module tone_player #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned BEAT_MS = 125,
    parameter int unsigned GAP_MS  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [3:0] note_code,
    input  logic [1:0] octave,
    input  logic [3:0] dur_units,
    input  logic       stop,
    output logic       note_ready,
    output logic       speaker,
    output logic       playing,
    output logic [3:0] cur_note,
    output logic [6:0] led_out
);

    // -------------------------------------------------------------------------
    // Timing constants
    // -------------------------------------------------------------------------
    localparam int unsigned UNIT    = CLK_HZ / 1000 * BEAT_MS;
    localparam int unsigned GAP_CYC = CLK_HZ / 1000 * GAP_MS;

    // The unit-cycle counter also times the gap, so size it for the larger
    // of the longest note (15 units) and the gap.
    localparam int unsigned CNT_MAX = (15 * UNIT > GAP_CYC) ? 15 * UNIT : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Middle-octave half periods, truncated.
    localparam int unsigned H_DO  = CLK_HZ / (2 * 262);
    localparam int unsigned H_RE  = CLK_HZ / (2 * 294);
    localparam int unsigned H_MI  = CLK_HZ / (2 * 330);
    localparam int unsigned H_FA  = CLK_HZ / (2 * 349);
    localparam int unsigned H_SOL = CLK_HZ / (2 * 392);
    localparam int unsigned H_LA  = CLK_HZ / (2 * 440);
    localparam int unsigned H_SI  = CLK_HZ / (2 * 494);

    // The low octave doubles the longest half period (do), so that sets the
    // phase counter width.
    localparam int unsigned PH_W = $clog2(2 * H_DO + 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1
`ifdef NOTE_GAP_EN
        ,
        ST_GAP  = 2'd2
`endif
    } state_t;

    state_t            state_reg,     state_next;
    logic [3:0]        note_reg,      note_next;
    logic [1:0]        oct_reg,       oct_next;
    logic [3:0]        dur_reg,       dur_next;
    logic [CNT_W-1:0]  unit_cnt_reg,  unit_cnt_next;
    logic [3:0]        units_cnt_reg, units_cnt_next;
    logic [PH_W-1:0]   phase_reg,     phase_next;
    logic              speaker_reg,   speaker_next;

    logic [PH_W-1:0]   mid_half;
    logic [PH_W-1:0]   half_sel;
    logic              is_rest;
    logic              unit_last;
    logic              note_last;

    // -------------------------------------------------------------------------
    // Half-period selection for the latched note and octave
    // -------------------------------------------------------------------------
    always_comb begin
        mid_half = '0;
        case (note_reg)
            4'd1:    mid_half = PH_W'(H_DO);
            4'd2:    mid_half = PH_W'(H_RE);
            4'd3:    mid_half = PH_W'(H_MI);
            4'd4:    mid_half = PH_W'(H_FA);
            4'd5:    mid_half = PH_W'(H_SOL);
            4'd6:    mid_half = PH_W'(H_LA);
            4'd7:    mid_half = PH_W'(H_SI);
            default: mid_half = '0;
        endcase

        half_sel = mid_half;
        case (oct_reg)
            2'b00:   half_sel = mid_half << 1;
            2'b10:   half_sel = mid_half >> 1;
            default: half_sel = mid_half;
        endcase
    end

    assign is_rest = (note_reg == 4'd0) || (note_reg > 4'd7);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            note_reg      <= '0;
            oct_reg       <= '0;
            dur_reg       <= '0;
            unit_cnt_reg  <= '0;
            units_cnt_reg <= '0;
            phase_reg     <= '0;
            speaker_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            note_reg      <= note_next;
            oct_reg       <= oct_next;
            dur_reg       <= dur_next;
            unit_cnt_reg  <= unit_cnt_next;
            units_cnt_reg <= units_cnt_next;
            phase_reg     <= phase_next;
            speaker_reg   <= speaker_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        note_next      = note_reg;
        oct_next       = oct_reg;
        dur_next       = dur_reg;
        unit_cnt_next  = unit_cnt_reg;
        units_cnt_next = units_cnt_reg;
        phase_next     = phase_reg;
        speaker_next   = speaker_reg;

        unit_last = (unit_cnt_reg == CNT_W'(UNIT - 1));
        note_last = (units_cnt_reg == (dur_reg - 4'd1));

        case (state_reg)
            ST_IDLE: begin
                speaker_next = 1'b0;
                // stop has priority over a simultaneous request
                if (note_valid && !stop) begin
                    state_next     = ST_PLAY;
                    note_next      = note_code;
                    oct_next       = octave;
                    dur_next       = (dur_units == 4'd0) ? 4'd1 : dur_units;
                    unit_cnt_next  = '0;
                    units_cnt_next = '0;
                    phase_next     = '0;
                end
            end

            ST_PLAY: begin
                if (stop) begin
                    state_next     = ST_IDLE;
                    note_next      = '0;
                    unit_cnt_next  = '0;
                    units_cnt_next = '0;
                    phase_next     = '0;
                    speaker_next   = 1'b0;
                end else begin
                    // Tone generation; rests keep the phase counter parked.
                    if (is_rest) begin
                        phase_next   = '0;
                        speaker_next = 1'b0;
                    end else if (phase_reg == (half_sel - 1'b1)) begin
                        phase_next   = '0;
                        speaker_next = ~speaker_reg;
                    end else begin
                        phase_next   = phase_reg + 1'b1;
                    end

                    // Duration: UNIT cycles per unit, dur_reg units in total.
                    if (unit_last) begin
                        unit_cnt_next = '0;
                        if (note_last) begin
                            // Expiry overrides any toggle on the same edge.
                            note_next      = '0;
                            units_cnt_next = '0;
                            phase_next     = '0;
                            speaker_next   = 1'b0;
`ifdef NOTE_GAP_EN
                            state_next     = ST_GAP;
`else
                            state_next     = ST_IDLE;
`endif
                        end else begin
                            units_cnt_next = units_cnt_reg + 1'b1;
                        end
                    end else begin
                        unit_cnt_next = unit_cnt_reg + 1'b1;
                    end
                end
            end

`ifdef NOTE_GAP_EN
            ST_GAP: begin
                speaker_next = 1'b0;
                if (stop || (unit_cnt_reg == CNT_W'(GAP_CYC - 1))) begin
                    state_next    = ST_IDLE;
                    unit_cnt_next = '0;
                end else begin
                    unit_cnt_next = unit_cnt_reg + 1'b1;
                end
            end
`endif

            default: begin
                state_next     = ST_IDLE;
                note_next      = '0;
                unit_cnt_next  = '0;
                units_cnt_next = '0;
                phase_next     = '0;
                speaker_next   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign note_ready = (state_reg == ST_IDLE);
    assign playing    = (state_reg == ST_PLAY);
    assign speaker    = speaker_reg;
    // note_reg is cleared whenever PLAY ends, so it already reads 0 outside PLAY.
    assign cur_note   = note_reg;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_led
            assign led_out[gi] = (note_reg == 4'(gi + 1));
        end
    endgenerate

endmodule
